// File: rtl/parity_frame_gen.sv
// parity_frame_gen: frame parity accumulator with valid/ready in and out.
// Optional PARITY_CHECK_EN adds exp_parity / err / err_cnt checking.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          word handshake (in_ready = state != DONE)
//   in_data[WIDTH]             data word
//   in_last                    final word of frame (on accepted beat)
//   odd_mode                   0 even / 1 odd, latched on first beat
//   out_valid/out_ready        result handshake
//   out_parity, out_beats[CW]  frame parity bit and beat count
//   frame_cnt[8]               completed-frame counter (wraps)
//   exp_parity, err, err_cnt   only with PARITY_CHECK_EN
module parity_frame_gen #(
    parameter int WIDTH     = 4,
    parameter int FRAME_LEN = 8,
    localparam int CW       = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             odd_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic [CW-1:0]    out_beats,
`ifdef PARITY_CHECK_EN
    input  logic             exp_parity,
    output logic             err,
    output logic [7:0]       err_cnt,
`endif
    output logic [7:0]       frame_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST_BEAT = CW'(FRAME_LEN);

    state_t        state;
    logic          acc;
    logic [CW-1:0] beats;
    logic          mode_q;

    logic          accept;
    logic          beat_par;
    logic          next_acc;
    logic [CW-1:0] next_beats;
    logic          next_mode;
    logic          frame_end;
    logic          final_par;

    assign in_ready = (state != DONE);
    assign accept   = in_valid && in_ready;

    // The first beat of a frame starts fresh and takes the live mode;
    // later beats fold into the running accumulator.
    always_comb begin
        beat_par   = ^in_data;
        next_acc   = beat_par;
        next_beats = CW'(1);
        next_mode  = odd_mode;
        if (state == ACCUM) begin
            next_acc   = acc ^ beat_par;
            next_beats = beats + CW'(1);
            next_mode  = mode_q;
        end
        frame_end = in_last || (next_beats == LAST_BEAT);
        final_par = next_acc ^ next_mode;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= 1'b0;
            beats      <= '0;
            mode_q     <= 1'b0;
            out_valid  <= 1'b0;
            out_parity <= 1'b0;
            out_beats  <= '0;
            frame_cnt  <= 8'd0;
`ifdef PARITY_CHECK_EN
            err        <= 1'b0;
            err_cnt    <= 8'd0;
`endif
        end else begin
            unique case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        mode_q <= next_mode;
                        acc    <= next_acc;
                        beats  <= next_beats;
                        if (frame_end) begin
                            state      <= DONE;
                            out_valid  <= 1'b1;
                            out_parity <= final_par;
                            out_beats  <= next_beats;
                            frame_cnt  <= frame_cnt + 8'd1;
`ifdef PARITY_CHECK_EN
                            err <= (final_par != exp_parity);
                            if ((final_par != exp_parity) &&
                                (err_cnt != 8'hFF))
                                err_cnt <= err_cnt + 8'd1;
`endif
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        acc       <= 1'b0;
                        beats     <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_parity_frame_gen.sv
// tb_parity_frame_gen: directed table-driven bench for parity_frame_gen.
// Frames from a vector table plus hand-written corner sequences.
module tb_parity_frame_gen;

    localparam int WIDTH     = 4;
    localparam int FRAME_LEN = 8;
    localparam int CW        = $clog2(FRAME_LEN + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             odd_mode;
    logic             out_valid;
    logic             out_ready;
    logic             out_parity;
    logic [CW-1:0]    out_beats;
    logic [7:0]       frame_cnt;
    logic             exp_parity;
`ifdef PARITY_CHECK_EN
    logic             err;
    logic [7:0]       err_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int exp_fc = 0;

    always #5 clk = ~clk;

    parity_frame_gen #(
        .WIDTH     (WIDTH),
        .FRAME_LEN (FRAME_LEN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .odd_mode   (odd_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_parity (out_parity),
        .out_beats  (out_beats),
`ifdef PARITY_CHECK_EN
        .exp_parity (exp_parity),
        .err        (err),
        .err_cnt    (err_cnt),
`endif
        .frame_cnt  (frame_cnt)
    );

    typedef struct {
        logic        mode;
        int          n;
        logic        use_last;
        logic [31:0] data;
        logic        exp_par;
        int          exp_beats;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid   = 1'b0;
        in_last    = 1'b0;
        in_data    = '0;
        odd_mode   = 1'b0;
        out_ready  = 1'b0;
        exp_parity = 1'b0;
    endtask

    // Drives one frame, flipping odd_mode after the first beat and
    // inserting a gap (in_last high, data X) after beat 0.
    task automatic run_frame(input vec_t v, input string tag);
        for (int i = 0; i < v.n; i++) begin
            in_valid   = 1'b1;
            in_data    = v.data[i*4 +: 4];
            in_last    = v.use_last && (i == v.n - 1);
            odd_mode   = (i == 0) ? v.mode : ~v.mode;
            exp_parity = v.exp_par;
            tick();
            if (i < v.n - 1) begin
                check({tag, " mid_valid"}, 32'(out_valid), 0);
            end
            if (i == 0 && v.n > 1) begin
                in_valid = 1'b0;
                in_last  = 1'b1;
                in_data  = 'x;
                tick();
                check({tag, " gap_valid"}, 32'(out_valid), 0);
                check({tag, " gap_ready"}, 32'(in_ready), 1);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        exp_fc   = (exp_fc + 1) % 256;
        check({tag, " out_valid"}, 32'(out_valid), 1);
        check({tag, " out_parity"}, 32'(out_parity), 32'(v.exp_par));
        check({tag, " out_beats"}, 32'(out_beats), 32'(v.exp_beats));
        check({tag, " frame_cnt"}, 32'(frame_cnt), 32'(exp_fc));
        check({tag, " ready_done"}, 32'(in_ready), 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " valid_clr"}, 32'(out_valid), 0);
        check({tag, " ready_back"}, 32'(in_ready), 1);
    endtask

    initial begin
        vecs[0] = '{1'b0, 8, 1'b0, 32'h11111111, 1'b0, 8};
        vecs[1] = '{1'b1, 2, 1'b1, 32'h00000007, 1'b0, 2};
        vecs[2] = '{1'b0, 1, 1'b1, 32'h0000000B, 1'b1, 1};
        vecs[3] = '{1'b1, 1, 1'b1, 32'h00000000, 1'b1, 1};
        vecs[4] = '{1'b0, 8, 1'b0, 32'h00000000, 1'b0, 8};
        vecs[5] = '{1'b1, 8, 1'b0, 32'hFFFFFFFF, 1'b1, 8};
        vecs[6] = '{1'b0, 3, 1'b1, 32'h00000731, 1'b0, 3};
        vecs[7] = '{1'b1, 8, 1'b1, 32'h00000001, 1'b0, 8};

        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst out_valid", 32'(out_valid), 0);
        check("rst in_ready", 32'(in_ready), 1);
        check("rst frame_cnt", 32'(frame_cnt), 0);
        check("rst out_parity", 32'(out_parity), 0);
        check("rst out_beats", 32'(out_beats), 0);
`ifdef PARITY_CHECK_EN
        check("rst err", 32'(err), 0);
        check("rst err_cnt", 32'(err_cnt), 0);
`endif

        for (int k = 0; k < 8; k++) begin
            run_frame(vecs[k], $sformatf("vec%0d", k));
        end

        // Backpressure: 2-beat even frame, sink stalls 5 cycles while
        // the source keeps offering a word that must not be consumed.
        in_valid = 1'b1;
        in_data  = 4'b0001;
        odd_mode = 1'b0;
        tick();
        in_last = 1'b1;
        tick();
        exp_fc  = (exp_fc + 1) % 256;
        in_data = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            check("bp out_valid", 32'(out_valid), 1);
            check("bp out_parity", 32'(out_parity), 0);
            check("bp out_beats", 32'(out_beats), 2);
            check("bp in_ready", 32'(in_ready), 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        check("bp valid_clr", 32'(out_valid), 0);
        check("bp ready_back", 32'(in_ready), 1);
        check("bp frame_cnt", 32'(frame_cnt), 32'(exp_fc));
        run_frame('{1'b0, 1, 1'b1, 32'h0, 1'b0, 1}, "post_bp");

        // Reset mid-frame: three accepted beats are discarded.
        in_valid = 1'b1;
        in_data  = 4'b0001;
        odd_mode = 1'b1;
        for (int b = 0; b < 3; b++) tick();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n  = 1'b1;
        exp_fc = 0;
        check("mrst out_valid", 32'(out_valid), 0);
        check("mrst frame_cnt", 32'(frame_cnt), 0);
        check("mrst in_ready", 32'(in_ready), 1);
        run_frame(vecs[0], "post_rst");

        // Frame counter wrap: back-to-back one-beat frames.
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        in_valid  = 1'b1;
        in_last   = 1'b1;
        in_data   = 4'b0000;
        out_ready = 1'b1;
        for (int e = 0; e < 510; e++) tick();
        check("wrap cnt255", 32'(frame_cnt), 255);
        tick();
        tick();
        check("wrap cnt0", 32'(frame_cnt), 0);
        idle_inputs();
        tick();

`ifdef PARITY_CHECK_EN
        // Computed parity 1 vs expected 0, then a matching frame.
        in_valid   = 1'b1;
        in_last    = 1'b1;
        in_data    = 4'b0001;
        exp_parity = 1'b0;
        tick();
        idle_inputs();
        check("chk err1", 32'(err), 1);
        check("chk err_valid", 32'(out_valid), 1);
        check("chk err_cnt1", 32'(err_cnt), 1);
        out_ready = 1'b1;
        tick();
        in_valid   = 1'b1;
        in_last    = 1'b1;
        in_data    = 4'b0001;
        exp_parity = 1'b1;
        out_ready  = 1'b0;
        tick();
        idle_inputs();
        check("chk err0", 32'(err), 0);
        check("chk err_cnt_hold", 32'(err_cnt), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
